com_param_bank: RTL and testbench

- Parametrised successor to the feature-extractor output register bank.
- Captures one record of NUM_OF_PARAM fiducial parameters (positions and amplitudes) on each hybd_done pulse into a DEPTH-record ring buffer.
- Serves addressed reads to the host com interface with a registered one-cycle ready handshake.
- Adds occupancy tracking, an explicit pop, a selectable overflow policy, out-of-range error flagging and an overflow counter, none of which the previous bank had.

---
 rtl/com_param_bank.sv | 133 +++++++++++++
 tb/tb_com_param_bank.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/com_param_bank.sv
// Ring buffer of DEPTH fiducial-parameter records with addressed host reads.
// Latency: a record is stored on the hybd_done edge; a read answers one cycle after com_req.
// Backpressure: none. A read is always answered. A write when full drops the oldest record or is discarded, depending on OVERWRITE.
module com_param_bank #(
  parameter int PARAM_W           = 16,
  parameter int IN_W              = 16,
  parameter int SIGN_EXT          = 1,
  parameter int NUM_OF_PARAM      = 16,
  parameter int LOG2_NUM_OF_PARAM = 4,
  parameter int DEPTH             = 8,
  parameter int LOG2_DEPTH        = 3,
  parameter int OVERWRITE         = 1,
  parameter int OVF_W             = 8
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    hybd_done,
  input  logic [NUM_OF_PARAM*IN_W-1:0]            param_i,
  input  logic                                    com_req,
  input  logic [LOG2_DEPTH+LOG2_NUM_OF_PARAM-1:0] addr_i,
  input  logic                                    com_pop,
  output logic                                    com_rdy,
  output logic [PARAM_W-1:0]                      data_o,
  output logic                                    com_err,
  output logic [LOG2_DEPTH:0]                     rec_cnt,
  output logic                                    full,
  output logic                                    empty,
  output logic [OVF_W-1:0]                        ovf_cnt
);

  localparam int REC_W = NUM_OF_PARAM * PARAM_W;
  localparam int CNT_W = LOG2_DEPTH + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [LOG2_NUM_OF_PARAM:0] LANE_LIM = (LOG2_NUM_OF_PARAM + 1)'(NUM_OF_PARAM);

  logic [REC_W-1:0]             mem [DEPTH];
  logic [REC_W-1:0]             rec_ext;
  logic [IN_W-1:0]              lane;
  logic [PARAM_W-1:0]           word;
  logic [LOG2_DEPTH-1:0]        wr_ptr;
  logic [LOG2_DEPTH-1:0]        rd_ptr;
  logic [CNT_W-1:0]             cnt_nxt;
  logic                         pop_ok;
  logic                         ovf_evt;
  logic                         do_wr;
  logic                         grow;
  logic                         rd_adv;
  logic [LOG2_DEPTH-1:0]        rd_off;
  logic [LOG2_NUM_OF_PARAM-1:0] rd_lane;
  logic [LOG2_DEPTH-1:0]        rd_slot;
  logic                         rd_vld;
  logic [PARAM_W-1:0]           rd_word;

  // Widen every input lane to the output word width (sign or zero fill)
  always_comb begin
    rec_ext = '0;
    lane    = '0;
    word    = '0;
    for (int k = 0; k < NUM_OF_PARAM; k++) begin
      lane             = param_i[k*IN_W +: IN_W];
      word             = '0;
      word[IN_W-1:0]   = lane;
      if (SIGN_EXT != 0 && lane[IN_W-1]) begin
        for (int b = IN_W; b < PARAM_W; b++) word[b] = 1'b1;
      end
      rec_ext[k*PARAM_W +: PARAM_W] = word;
    end
  end

  // A pop on a non-empty buffer frees a slot, so a simultaneous write never overflows
  assign pop_ok  = com_pop & ~empty;
  assign ovf_evt = hybd_done & full & ~pop_ok;
  assign do_wr   = hybd_done & ~(ovf_evt & (OVERWRITE == 0));
  assign grow    = do_wr & ~ovf_evt;
  assign rd_adv  = pop_ok | (ovf_evt & (OVERWRITE != 0));

  // Next occupancy: +1 on a net write, -1 on a net pop
  always_comb begin
    cnt_nxt = rec_cnt;
    if (grow && !pop_ok) begin
      cnt_nxt = rec_cnt + CNT_W'(1);
    end else if (pop_ok && !grow) begin
      cnt_nxt = rec_cnt - CNT_W'(1);
    end
  end

  // Read decode against the current (pre-edge) oldest pointer and occupancy
  assign rd_off  = addr_i[LOG2_DEPTH+LOG2_NUM_OF_PARAM-1:LOG2_NUM_OF_PARAM];
  assign rd_lane = addr_i[LOG2_NUM_OF_PARAM-1:0];
  assign rd_slot = rd_ptr + rd_off;
  assign rd_vld  = ({1'b0, rd_off} < rec_cnt) && ({1'b0, rd_lane} < LANE_LIM);
  assign rd_word = mem[rd_slot][int'(rd_lane)*PARAM_W +: PARAM_W];

  // Record storage; contents are never readable while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= rec_ext;
  end

  // Pointers, occupancy flags and saturating overflow counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rec_cnt <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      ovf_cnt <= '0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
      if (rd_adv) rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
      rec_cnt <= cnt_nxt;
      full    <= (cnt_nxt == CNT_FULL);
      empty   <= (cnt_nxt == '0);
      if (ovf_evt && ovf_cnt != '1) ovf_cnt <= ovf_cnt + OVF_W'(1);
    end
  end

  // Registered read response; data and error hold while no request is answered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      com_rdy <= 1'b0;
      com_err <= 1'b0;
      data_o  <= '0;
    end else begin
      com_rdy <= com_req;
      if (com_req) begin
        com_err <= ~rd_vld;
        data_o  <= rd_vld ? rd_word : '0;
      end
    end
  end

endmodule

// File: tb/tb_com_param_bank.sv
// Bench for com_param_bank: three configurations share one stimulus stream.
// d0 = defaults, d1 = 11-bit sign-extended lanes / 12 params / discard-on-full,
// d2 = 11-bit zero-extended lanes / overwrite-on-full.
module tb_com_param_bank;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         hybd_done;
  logic         com_req;
  logic         com_pop;
  logic [6:0]   addr;
  logic [255:0] praw;
  logic [131:0] p1;
  logic [175:0] p2;

  logic         rdy_o   [3];
  logic [15:0]  dat_o   [3];
  logic         err_o   [3];
  logic [3:0]   cnt_o   [3];
  logic         full_o  [3];
  logic         empty_o [3];
  logic [7:0]   ovf_o   [3];

  // Reference model: one queue of raw records per configuration, oldest first
  logic [255:0] mq [3][$];
  logic         exp_rdy [3];
  logic [15:0]  exp_dat [3];
  logic         exp_err [3];
  int           exp_ovf [3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  // Narrow lanes for the 11-bit configurations
  always_comb begin
    p1 = '0;
    p2 = '0;
    for (int k = 0; k < 12; k++) p1[k*11 +: 11] = praw[k*16 +: 11];
    for (int k = 0; k < 16; k++) p2[k*11 +: 11] = praw[k*16 +: 11];
  end

  com_param_bank u_d0 (
    .clk(clk), .reset_n(reset_n), .hybd_done(hybd_done), .param_i(praw),
    .com_req(com_req), .addr_i(addr), .com_pop(com_pop),
    .com_rdy(rdy_o[0]), .data_o(dat_o[0]), .com_err(err_o[0]), .rec_cnt(cnt_o[0]),
    .full(full_o[0]), .empty(empty_o[0]), .ovf_cnt(ovf_o[0])
  );

  com_param_bank #(.IN_W(11), .SIGN_EXT(1), .NUM_OF_PARAM(12), .OVERWRITE(0)) u_d1 (
    .clk(clk), .reset_n(reset_n), .hybd_done(hybd_done), .param_i(p1),
    .com_req(com_req), .addr_i(addr), .com_pop(com_pop),
    .com_rdy(rdy_o[1]), .data_o(dat_o[1]), .com_err(err_o[1]), .rec_cnt(cnt_o[1]),
    .full(full_o[1]), .empty(empty_o[1]), .ovf_cnt(ovf_o[1])
  );

  com_param_bank #(.IN_W(11), .SIGN_EXT(0), .OVERWRITE(1)) u_d2 (
    .clk(clk), .reset_n(reset_n), .hybd_done(hybd_done), .param_i(p2),
    .com_req(com_req), .addr_i(addr), .com_pop(com_pop),
    .com_rdy(rdy_o[2]), .data_o(dat_o[2]), .com_err(err_o[2]), .rec_cnt(cnt_o[2]),
    .full(full_o[2]), .empty(empty_o[2]), .ovf_cnt(ovf_o[2])
  );

  function automatic int nlanes(input int d);
    return (d == 1) ? 12 : 16;
  endfunction

  // Expected output word: keep the low IN_W bits of the raw lane, then extend
  function automatic logic [15:0] lane_val(input int d, input logic [255:0] rec, input int k);
    int          w;
    logic [15:0] v;
    logic [15:0] m;
    w = (d == 0) ? 16 : 11;
    m = 16'((32'd1 << w) - 1);
    v = rec[k*16 +: 16] & m;
    if (d != 2 && v[w-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock: answer the read from the current contents, then apply write/pop
  task automatic model(input logic hd, input logic [255:0] p, input logic rq,
                       input logic [6:0] a, input logic pp);
    int  r;
    int  k;
    logic pop_ok;
    r = int'(a[6:4]);
    k = int'(a[3:0]);
    for (int d = 0; d < 3; d++) begin
      exp_rdy[d] = rq;
      if (rq) begin
        if (r < mq[d].size() && k < nlanes(d)) begin
          exp_dat[d] = lane_val(d, mq[d][r], k);
          exp_err[d] = 1'b0;
        end else begin
          exp_dat[d] = 16'h0000;
          exp_err[d] = 1'b1;
        end
      end
      pop_ok = pp && (mq[d].size() > 0);
      if (hd) begin
        if (pop_ok) begin
          void'(mq[d].pop_front());
          mq[d].push_back(p);
        end else if (mq[d].size() < 8) begin
          mq[d].push_back(p);
        end else begin
          if (exp_ovf[d] < 255) exp_ovf[d]++;
          if (d != 1) begin
            void'(mq[d].pop_front());
            mq[d].push_back(p);
          end
        end
      end else if (pop_ok) begin
        void'(mq[d].pop_front());
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("c%0d_d%0d_rdy", cyc, d),   32'(rdy_o[d]),   32'(exp_rdy[d]));
      chk($sformatf("c%0d_d%0d_dat", cyc, d),   32'(dat_o[d]),   32'(exp_dat[d]));
      chk($sformatf("c%0d_d%0d_err", cyc, d),   32'(err_o[d]),   32'(exp_err[d]));
      chk($sformatf("c%0d_d%0d_cnt", cyc, d),   32'(cnt_o[d]),   32'(mq[d].size()));
      chk($sformatf("c%0d_d%0d_full", cyc, d),  32'(full_o[d]),  32'(mq[d].size() == 8));
      chk($sformatf("c%0d_d%0d_empty", cyc, d), 32'(empty_o[d]), 32'(mq[d].size() == 0));
      chk($sformatf("c%0d_d%0d_ovf", cyc, d),   32'(ovf_o[d]),   32'(exp_ovf[d]));
    end
  endtask

  task automatic step(input logic hd, input logic [255:0] p, input logic rq,
                      input logic [6:0] a, input logic pp);
    hybd_done = hd;
    praw      = p;
    com_req   = rq;
    addr      = a;
    com_pop   = pp;
    model(hd, p, rq, a, pp);
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    hybd_done = 1'b0;
    com_req   = 1'b0;
    com_pop   = 1'b0;
    addr      = '0;
    for (int d = 0; d < 3; d++) begin
      mq[d].delete();
      exp_rdy[d] = 1'b0;
      exp_dat[d] = 16'h0000;
      exp_err[d] = 1'b0;
      exp_ovf[d] = 0;
    end
    #2;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] tag);
    logic [255:0] p;
    p = rand256();
    p[15:0] = tag;
    step(1'b1, p, 1'b0, 7'h00, 1'b0);
  endtask

  task automatic rd(input logic [2:0] r, input logic [3:0] k);
    step(1'b0, rand256(), 1'b1, {r, k}, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, rand256(), 1'b0, 7'h00, 1'b0);
  endtask

  initial begin
    logic [255:0] p;
    reset_n   = 1'b1;
    hybd_done = 1'b0;
    com_req   = 1'b0;
    com_pop   = 1'b0;
    addr      = '0;
    praw      = '0;
    #1;
    do_reset();
    chk("rst_empty", 32'(empty_o[0]), 32'd1);
    chk("rst_cnt",   32'(cnt_o[0]),   32'd0);

    // Three tagged captures, then addressed reads with a one-cycle answer
    wr(16'h0001);
    wr(16'h0002);
    wr(16'h0003);
    chk("cnt3",   32'(cnt_o[0]),   32'd3);
    chk("empty3", 32'(empty_o[0]), 32'd0);
    rd(3'd0, 4'd0);
    chk("rd00_rdy", 32'(rdy_o[0]), 32'd1);
    chk("rd00_dat", 32'(dat_o[0]), 32'h0001);
    chk("rd00_err", 32'(err_o[0]), 32'd0);
    idle();
    chk("rdy_drop", 32'(rdy_o[0]), 32'd0);
    chk("dat_hold", 32'(dat_o[0]), 32'h0001);
    rd(3'd2, 4'd0);
    chk("rd20_dat", 32'(dat_o[0]), 32'h0003);

    // Lane extension: 0x7FF on lane 4 of the fourth record
    p = rand256();
    p[4*16 +: 16] = 16'h07FF;
    step(1'b1, p, 1'b0, 7'h00, 1'b0);
    rd(3'd3, 4'd4);
    chk("ext_d0",   32'(dat_o[0]), 32'h07FF);
    chk("sext_d1",  32'(dat_o[1]), 32'hFFFF);
    chk("zext_d2",  32'(dat_o[2]), 32'h07FF);

    // Ten captures into eight slots: overwrite vs discard
    do_reset();
    for (int t = 1; t <= 10; t++) wr(16'(t));
    chk("ovw_cnt",  32'(cnt_o[0]),  32'd8);
    chk("ovw_full", 32'(full_o[0]), 32'd1);
    chk("ovw_ovf",  32'(ovf_o[0]),  32'd2);
    chk("dis_ovf",  32'(ovf_o[1]),  32'd2);
    rd(3'd0, 4'd0);
    chk("ovw_old",  32'(dat_o[0]), 32'd3);
    chk("dis_old",  32'(dat_o[1]), 32'd1);
    rd(3'd7, 4'd0);
    chk("ovw_new",  32'(dat_o[0]), 32'd10);
    chk("dis_new",  32'(dat_o[1]), 32'd8);

    // Full: capture and pop together is not an overflow
    p = rand256();
    p[15:0] = 16'd11;
    step(1'b1, p, 1'b0, 7'h00, 1'b1);
    chk("wp_cnt", 32'(cnt_o[0]), 32'd8);
    chk("wp_ovf", 32'(ovf_o[0]), 32'd2);
    rd(3'd0, 4'd0);
    chk("wp_old_d0", 32'(dat_o[0]), 32'd4);
    chk("wp_old_d1", 32'(dat_o[1]), 32'd2);

    // Pop while empty, then capture+pop while empty
    do_reset();
    step(1'b0, rand256(), 1'b0, 7'h00, 1'b1);
    chk("pop_empty", 32'(cnt_o[0]), 32'd0);
    p = rand256();
    p[15:0] = 16'd5;
    step(1'b1, p, 1'b0, 7'h00, 1'b1);
    chk("wp_empty", 32'(cnt_o[0]), 32'd1);

    // Out-of-range record offset and lane index
    wr(16'd6);
    rd(3'd2, 4'd0);
    chk("oor_rdy", 32'(rdy_o[0]), 32'd1);
    chk("oor_err", 32'(err_o[0]), 32'd1);
    chk("oor_dat", 32'(dat_o[0]), 32'd0);
    rd(3'd0, 4'd13);
    chk("lane13_d1", 32'(err_o[1]), 32'd1);
    chk("lane13_d0", 32'(err_o[0]), 32'd0);

    // Four back-to-back reads of offset 2 with a capture in the second cycle
    rd(3'd2, 4'd0);
    chk("b1_err", 32'(err_o[0]), 32'd1);
    p = rand256();
    p[15:0] = 16'd7;
    step(1'b1, p, 1'b1, {3'd2, 4'd0}, 1'b0);
    chk("b2_rdy", 32'(rdy_o[0]), 32'd1);
    chk("b2_err", 32'(err_o[0]), 32'd1);
    rd(3'd2, 4'd0);
    chk("b3_rdy", 32'(rdy_o[0]), 32'd1);
    chk("b3_dat", 32'(dat_o[0]), 32'd7);
    rd(3'd2, 4'd0);
    chk("b4_rdy", 32'(rdy_o[0]), 32'd1);

    // Reset mid-burst drops the answer immediately
    com_req = 1'b1;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("mid_rst_rdy_d%0d", d), 32'(rdy_o[d]), 32'd0);
      chk($sformatf("mid_rst_cnt_d%0d", d), 32'(cnt_o[d]), 32'd0);
    end
    do_reset();

    // Random traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 2) == 0), rand256(), ($urandom_range(0, 1) == 1),
           7'($urandom), ($urandom_range(0, 4) == 0));
    end

    // Overflow counter saturation
    do_reset();
    for (int t = 0; t < 270; t++) wr(16'(t));
    chk("ovf_sat_d0", 32'(ovf_o[0]), 32'd255);
    chk("ovf_sat_d1", 32'(ovf_o[1]), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
